screen_state_writer: RTL

Producer side of the 32-cell game screen bus. Owns the `ScreenValues` register, scrambles it from an LFSR at game start, and applies player moves (cursor left/right, "lights-out" toggle of the cursor cell and its two neighbours). It consumes the registered win flag returned by the win checker and freezes the board once the game is won.

---
 rtl/screen_state_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/screen_state_writer.sv
// Producer of the game screen bus: LFSR scramble, cursor moves, lights-out toggles, win freeze.
// Define SCREEN_WRAP_EN to make the cursor and toggle neighbours wrap around the bus.
module screen_state_writer #(
  parameter int          NumberOfBits = 31,
  parameter logic [31:0] SEED         = 32'hACE1_1234
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              btn_left,
  input  logic                              btn_right,
  input  logic                              btn_toggle,
  input  logic                              btn_new,
  input  logic                              win,
  output logic [NumberOfBits:0]             ScreenValues,
  output logic [$clog2(NumberOfBits+1)-1:0] cursor,
  output logic                              won
);

  localparam int W  = NumberOfBits + 1;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CMAX = CW'(NumberOfBits);
  localparam logic [31:0] TAPS = 32'h8020_0003;

`ifdef SCREEN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef logic [NumberOfBits:0] board_t;

  typedef enum logic [1:0] {
    S_SCR,
    S_PLAY,
    S_WON
  } state_t;

  state_t        state_q;
  board_t        screen_q;
  logic [CW-1:0] cursor_q;
  logic          won_q;
  logic [1:0]    settle_q;
  logic [31:0]   lfsr_q;
  logic [31:0]   lfsr_d;
  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  logic [3:0]    h_q;
  logic [3:0]    btn;
  logic [3:0]    pulse;
  logic          p_left;
  logic          p_right;
  logic          p_tog;
  logic          p_new;
  board_t        cand;
  board_t        tmask;
  logic [CW-1:0] cur_left;
  logic [CW-1:0] cur_right;
  logic          cand_win;

  assign btn     = {btn_new, btn_toggle, btn_right, btn_left};
  assign pulse   = s2_q & ~h_q;
  assign p_left  = pulse[0];
  assign p_right = pulse[1];
  assign p_tog   = pulse[2];
  assign p_new   = pulse[3];

  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign cand   = lfsr_d[NumberOfBits:0];

  function automatic logic is_win(board_t v);
    board_t alt;
    for (int i = 0; i < W; i++) alt[i] = i[0];
    return (v == '0) || (v == '1) || (v == alt) || (v == ~alt);
  endfunction

  assign cand_win = is_win(cand);

  // Neighbour cells either wrap or are clipped at the bus edges.
  always_comb begin
    tmask = '0;
    tmask[cursor_q] = 1'b1;
    if (cursor_q != '0) tmask[cursor_q - 1'b1] = 1'b1;
    else if (WRAP)      tmask[NumberOfBits] = 1'b1;
    if (cursor_q != CMAX) tmask[cursor_q + 1'b1] = 1'b1;
    else if (WRAP)        tmask[0] = 1'b1;
  end

  always_comb begin
    cur_left  = cursor_q - 1'b1;
    cur_right = cursor_q + 1'b1;
    if (cursor_q == '0)   cur_left  = WRAP ? CMAX : '0;
    if (cursor_q == CMAX) cur_right = WRAP ? '0 : CMAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_SCR;
      screen_q <= '0;
      cursor_q <= '0;
      won_q    <= 1'b0;
      settle_q <= 2'd2;
      lfsr_q   <= SEED;
      s1_q     <= '0;
      s2_q     <= '0;
      h_q      <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      s1_q   <= btn;
      s2_q   <= s1_q;
      h_q    <= s2_q;
      unique case (state_q)
        S_SCR: begin
          if (!cand_win) begin
            screen_q <= cand;
            cursor_q <= '0;
            settle_q <= 2'd2;
            state_q  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (p_new) begin
            state_q <= S_SCR;
          end else begin
            if (p_tog) screen_q <= screen_q ^ tmask;
            unique case (1'b1)
              (p_left && !p_right): cursor_q <= cur_left;
              (p_right && !p_left): cursor_q <= cur_right;
              default: ;
            endcase
            // A change this cycle makes the incoming win flag stale.
            if (p_tog) begin
              settle_q <= 2'd2;
            end else begin
              if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
              if (win && settle_q == 2'd0) begin
                state_q <= S_WON;
                won_q   <= 1'b1;
              end
            end
          end
        end
        S_WON: begin
          if (p_new) begin
            state_q <= S_SCR;
            won_q   <= 1'b0;
          end
        end
        default: state_q <= S_SCR;
      endcase
    end
  end

  assign ScreenValues = screen_q;
  assign cursor       = cursor_q;
  assign won          = won_q;

endmodule
